// File: rtl/wav_play_sched_if.sv
// Store read port and DSP sample stream of the WAV playback scheduler.
interface wav_play_sched_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int ADDR_W       = 19
);
  logic                           mem_rd_en;
  logic        [ADDR_W-1:0]       mem_rd_addr;
  logic signed [SAMPLE_WIDTH-1:0] mem_rd_data;
  logic signed [SAMPLE_WIDTH-1:0] out_data;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    output mem_rd_en, mem_rd_addr, out_data, out_valid,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, out_data, out_valid,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/wav_play_sched.sv
// Fetches one store sample per CLK_DIV cycles and presents it to the DSP on valid/ready.
// Define WAV_PLAY_SCHED_LOOP_EN to honour i_loop (wrap to sample 0 at the end).
module wav_play_sched #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int ADDR_W       = 19,
  parameter int CLK_DIV      = 2083
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic [ADDR_W:0]   i_num_samples,
  input  logic              i_src_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_overrun_cnt,
  wav_play_sched_if.master  bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W:0]  MAX_NUM = {1'b1, {ADDR_W{1'b0}}};
`ifdef WAV_PLAY_SCHED_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_DATA, S_WAIT_TICK, S_DONE
  } state_t;

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_addr;
  logic [ADDR_W-1:0]        r_rd_addr;
  logic [ADDR_W:0]          r_num;
  logic [DIV_W-1:0]         r_div;
  logic signed [SAMPLE_WIDTH-1:0] r_out_data;
  logic                     r_out_valid;
  logic                     r_err;
  logic [15:0]              r_ovr;

  logic w_busy, w_idle_like, w_can_start, w_num_ok, w_accept, w_last, w_take, w_wrap;

  assign w_busy      = (r_state == S_FETCH) || (r_state == S_WAIT_DATA) || (r_state == S_WAIT_TICK);
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_can_start = w_idle_like && i_start && !i_stop;
  assign w_num_ok    = (i_num_samples != '0) && (i_num_samples <= MAX_NUM);
  assign w_accept    = w_can_start && i_src_ready && w_num_ok;
  assign w_last      = ({1'b0, r_addr} == (r_num - 1'b1));
  assign w_take      = !r_out_valid || bus.out_ready;
  assign w_wrap      = LOOP_EN & i_loop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rd_addr   <= '0;
      r_num       <= '0;
      r_div       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_ovr       <= '0;
    end else begin
      r_err <= 1'b0;
      // Free-running divider keeps fetches exactly CLK_DIV cycles apart.
      if (w_busy) r_div <= (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

      if (i_stop && r_state != S_IDLE) begin
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_accept) begin
              r_num       <= i_num_samples;
              r_addr      <= '0;
              r_rd_addr   <= '0;
              r_div       <= '0;
              r_ovr       <= '0;
              r_out_valid <= 1'b0;
              r_state     <= S_FETCH;
            end else if (w_can_start) begin
              r_err <= 1'b1;
            end
          end
          S_FETCH: r_state <= S_WAIT_DATA;
          S_WAIT_DATA: begin
            if (w_take) begin
              r_out_data  <= bus.mem_rd_data;
              r_out_valid <= 1'b1;
            end else if (r_ovr != 16'hFFFF) begin
              r_ovr <= r_ovr + 16'd1;
            end
            if (w_last) begin
              if (w_wrap) begin
                r_addr  <= '0;
                r_state <= S_WAIT_TICK;
              end else begin
                r_state <= S_DONE;
              end
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_WAIT_TICK;
            end
          end
          S_WAIT_TICK: begin
            if (r_div == DIV_MAX) begin
              r_rd_addr <= r_addr;
              r_state   <= S_FETCH;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_rd_en   = (r_state == S_FETCH);
  assign bus.mem_rd_addr = r_rd_addr;
  assign bus.out_data    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign o_busy          = w_busy;
  assign o_done          = (r_state == S_DONE);
  assign o_err           = r_err;
  assign o_overrun_cnt   = r_ovr;

endmodule

// File: tb/tb_wav_play_sched.sv
// Scoreboard bench for wav_play_sched: 24-bit and 16-bit instances share control stimulus.
module tb_wav_play_sched;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst, start, stop, loop, src_ready, ready;
  logic [AW:0]   num;
  logic [23:0]   base;
  logic          busy, done, err;
  logic [15:0]   ovr;
  logic          busy16, done16, err16;
  logic [15:0]   ovr16;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_err = 0;
  int            e0;

  typedef struct {
    logic [23:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  wav_play_sched_if #(.SAMPLE_WIDTH(24), .ADDR_W(AW)) bus ();
  wav_play_sched_if #(.SAMPLE_WIDTH(16), .ADDR_W(AW)) bus16 ();

  wav_play_sched #(.SAMPLE_WIDTH(24), .ADDR_W(AW), .CLK_DIV(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_loop(loop),
    .i_num_samples(num), .i_src_ready(src_ready), .o_busy(busy), .o_done(done),
    .o_err(err), .o_overrun_cnt(ovr), .bus(bus.master)
  );

  wav_play_sched #(.SAMPLE_WIDTH(16), .ADDR_W(AW), .CLK_DIV(4)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_loop(loop),
    .i_num_samples(num), .i_src_ready(src_ready), .o_busy(busy16), .o_done(done16),
    .o_err(err16), .o_overrun_cnt(ovr16), .bus(bus16.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.out_ready   = ready;
  assign bus16.out_ready = ready;

  // Store model: synchronous read, word = base + address.
  logic [23:0] st_word, st_word16;
  assign st_word   = base + 24'(bus.mem_rd_addr);
  assign st_word16 = base + 24'(bus16.mem_rd_addr);
  always @(posedge clk) begin
    if (bus.mem_rd_en)   bus.mem_rd_data   <= st_word;
    if (bus16.mem_rd_en) bus16.mem_rd_data <= st_word16[15:0];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", 32'($unsigned(bus.out_data)), {8'h0, e.data});
        chk("data16", 32'($unsigned(bus16.out_data)), {16'h0, e.data[15:0]});
        chk("valid16", 32'(bus16.out_valid), 32'd1);
        if (e.cyc != 0) chk("xfer_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic push(input logic [23:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic go(input logic [AW:0] n, input logic lp);
    num   = n;
    loop  = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_rd_en"},   32'(bus.mem_rd_en), 32'd0);
    chk({t, "_rd_addr"}, 32'(bus.mem_rd_addr), 32'd0);
    chk({t, "_data"},    32'($unsigned(bus.out_data)), 32'd0);
    chk({t, "_valid"},   32'(bus.out_valid), 32'd0);
    chk({t, "_busy"},    32'(busy), 32'd0);
    chk({t, "_done"},    32'(done), 32'd0);
    chk({t, "_err"},     32'(err), 32'd0);
    chk({t, "_ovr"},     32'(ovr), 32'd0);
  endtask

  task automatic reject(input string t, input logic sr, input logic [AW:0] n);
    src_ready = sr;
    go(n, 1'b0);
    src_ready = 1'b1;
    chk({t, "_err1"}, 32'(err), 32'd1);
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_rd"},   32'(bus.mem_rd_en), 32'd0);
    tick();
    chk({t, "_err0"}, 32'(err), 32'd0);
    chk({t, "_rd2"},  32'(bus.mem_rd_en), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; src_ready = 1'b1;
    ready = 1'b1; num = '0; base = 24'd1;
    repeat (3) tick();
    chk_rst("reset");
    rst = 1'b0;
    tick();

    reject("rej_src", 1'b0, 20'd3);
    reject("rej_zero", 1'b1, 20'd0);
    reject("rej_big", 1'b1, 20'h80001);

    // Normal playback: samples 1,2,3 at E2/E6/E10.
    e0 = cyc + 1;
    push(24'd1, e0 + 2); push(24'd2, e0 + 6); push(24'd3, e0 + 10);
    go(20'd3, 1'b0);
    chk("t1_rd_en", 32'(bus.mem_rd_en), 32'd1);
    chk("t1_busy",  32'(busy), 32'd1);
    wait_to(e0 + 4);
    chk("t1_rd_addr1", 32'(bus.mem_rd_addr), 32'd1);
    wait_to(e0 + 9);
    chk("t1_done_early", 32'(done), 32'd0);
    wait_to(e0 + 10);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_ovr", 32'(ovr), 32'd0);
    tick();

    // DSP stalls: first sample held, two overruns.
    ready = 1'b0;
    e0 = cyc + 1;
    push(24'd1, 0);
    go(20'd3, 1'b0);
    wait_to(e0 + 11);
    chk("t2_hold", 32'($unsigned(bus.out_data)), 32'd1);
    chk("t2_ovr",  32'(ovr), 32'd2);
    chk("t2_done", 32'(done), 32'd1);
    ready = 1'b1;
    tick();
    chk("t2_valid_clr", 32'(bus.out_valid), 32'd0);

    // Stop in WAIT_TICK after first sample, then replay.
    ready = 1'b0;
    e0 = cyc + 1;
    go(20'd3, 1'b0);
    wait_to(e0 + 2);
    chk("t3_valid", 32'(bus.out_valid), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_busy",  32'(busy), 32'd0);
    chk("t3_valid0", 32'(bus.out_valid), 32'd0);
    chk("t3_done",  32'(done), 32'd0);
    ready = 1'b1;
    e0 = cyc + 1;
    push(24'd1, e0 + 2); push(24'd2, e0 + 6); push(24'd3, e0 + 10);
    go(20'd3, 1'b0);
    wait_to(e0 + 11);

    // Sign bit passthrough (16-bit instance sees 8000/8001).
    base = 24'hFF8000;
    e0 = cyc + 1;
    push(24'hFF8000, e0 + 2); push(24'hFF8001, e0 + 6);
    go(20'd2, 1'b0);
    wait_to(e0 + 7);
    chk("t4_done", 32'(done), 32'd1);
    base = 24'd1;
    tick();

    e0 = cyc + 1;
`ifdef WAV_PLAY_SCHED_LOOP_EN
    for (int k = 0; k < 5; k++) push(24'(1 + (k % 2)), e0 + 2 + 4 * k);
    go(20'd2, 1'b1);
    wait_to(e0 + 18);
    chk("t5_nodone", 32'(done), 32'd0);
    chk("t5_busy",   32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_stopped", 32'(busy), 32'd0);
`else
    push(24'd1, e0 + 2); push(24'd2, e0 + 6);
    go(20'd2, 1'b1);
    wait_to(e0 + 7);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
`endif
    loop = 1'b0;
    tick();

    // Reset lands on the WAIT_DATA edge with start held.
    e0 = cyc + 1;
    go(20'd3, 1'b0);
    wait_to(e0 + 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    chk_rst("midrst");
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("midrst_idle", 32'(busy), 32'd0);

    repeat (4) tick();
    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
